gerador_trepidacao: RTL and testbench
=====================================

GERADOR_TREPIDACAO -- requirements
Module: gerador_trepidacao

Interface
REQ-001 SHALL have parameter BOUNCES, default 5, number of output transition events per bounce burst (odd, 1..15).
REQ-002 SHALL have parameter MAX_GAP, default 8, maximum pseudo-random cycles between events (power of two, 2..128).
REQ-003 SHALL have parameter FIXED_GAP, default 0, nonzero value overrides the random gap with that constant (1..128).
REQ-004 SHALL have parameter SETTLE, default 4, stable cycles after the last event before settled pulses (1..255).
REQ-005 SHALL have parameter SEED, default 8'hA5, nonzero LFSR reset value.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port clear_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port level_in  input  1  clean switch level, synchronous to clk.
REQ-009 SHALL have port bounce_out  output  1  emulated bouncing contact level.
REQ-010 SHALL have port busy  output  1  high while a burst or settle interval is in progress.
REQ-011 SHALL have port settled  output  1  one-cycle pulse when bounce_out has been stable at target for SETTLE cycles.

Function
REQ-012 SHALL implement FSM states IDLE, BOUNCE and SETTLE; IDLE after reset.
REQ-013 SHALL, in IDLE at an edge where level_in != bounce_out, latch target <= level_in, invert bounce_out (event 1), load gap, and enter BOUNCE; busy goes high at that edge.
REQ-014 SHALL, in BOUNCE, decrement the gap counter each cycle and fire the next event at the edge where it reaches zero.
REQ-015 SHALL make events 1..BOUNCES-1 invert bounce_out, and make event BOUNCES drive bounce_out <= target and enter SETTLE.
REQ-016 SHALL set each gap to FIXED_GAP when FIXED_GAP != 0, else (lfsr[7:0] & (MAX_GAP-1)) + 1, giving 1..MAX_GAP cycles.
REQ-017 SHALL advance the 8-bit Fibonacci LFSR (taps 8,6,5,4) every cycle regardless of state.
REQ-018 SHALL, in BOUNCE, update target <= level_in every cycle without resetting the event count; the final event drives the latest target.
REQ-019 SHALL, with BOUNCES=1, drive bounce_out to target on event 1 and go directly to SETTLE.
REQ-020 SHALL, in SETTLE, count SETTLE cycles; at the edge the count completes, pulse settled for one cycle, clear busy, and return to IDLE.
REQ-021 SHALL, in SETTLE at an edge where level_in != bounce_out, restart as in REQ-013 (event count reset, no settled pulse).
REQ-022 SHALL NOT let settled and the start of a new burst occur at the same edge; restart takes priority.
REQ-023 SHALL, in IDLE with level_in == bounce_out, hold all outputs; busy=0, settled=0.

Reset
REQ-024 SHALL, on clear_n low, immediately force state=IDLE, bounce_out=0, busy=0, settled=0, counters=0 and lfsr=SEED.
REQ-025 SHALL abandon any burst when reset is asserted mid-operation.
REQ-026 SHALL start a burst at the first edge after clear_n release if level_in=1.

Structure
REQ-027 SHALL put the FSM state encoding (2-bit IDLE=0, BOUNCE=1, SETTLE=2) and the LFSR tap constant in the shared package.
REQ-028 SHALL instantiate the LFSR as sub-module lfsr8 (ports clk, clear_n, seed, q).
REQ-029 SHALL size counters as 8-bit gap/settle and 4-bit event, with parameter range checks at elaboration.

Verification
REQ-030 SHALL cover this case: with FIXED_GAP=2, BOUNCES=3, SETTLE=4, level_in 0->1 sampled at edge k -> bounce_out 1@k, 0@k+2, 1@k+4; settled pulse @k+8; busy high k..k+7.
REQ-031 SHALL cover this case: with the same parameters, level_in returns to 0 at k+3 -> bounce_out 1@k, 0@k+2, stays 0@k+4; settled @k+8 with bounce_out=0.
REQ-032 SHALL cover this case: with the same parameters, level_in toggles at k+6 during SETTLE -> new burst starts @k+6, no settled pulse @k+8.
REQ-033 SHALL cover this case: clear_n low at k+3 mid-burst -> bounce_out=0, busy=0 immediately; after release with level_in=1, a new burst starts at the next edge.
REQ-034 SHALL cover this case: with FIXED_GAP=0, MAX_GAP=8, 1000 random bursts -> every gap is within 1..8 cycles, final bounce_out equals level_in, and exactly one settled pulse per undisturbed burst.

Source files
------------

// File: rtl/gerador_trepidacao_pkg.sv
// Shared definitions for the contact-bounce emulator: FSM encoding, counter
// widths, LFSR tap mask and the random-gap helper.
package gerador_trepidacao_pkg;

    localparam int unsigned LFSR_W   = 8;
    localparam int unsigned GAP_W    = 8;
    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned EVT_W    = 4;
    localparam int unsigned STATE_W  = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BOUNCE = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;

    // Fibonacci taps 8,6,5,4 expressed as a mask over q[7:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Random gap in 1..mask+1 cycles; mask is MAX_GAP-1 (MAX_GAP a power of two)
    function automatic logic [GAP_W-1:0] gap_from_lfsr(input logic [LFSR_W-1:0] r,
                                                       input logic [GAP_W-1:0]  mask);
        return GAP_W'(r & mask) + GAP_W'(1);
    endfunction

endpackage

// File: rtl/gerador_trepidacao_lfsr8.sv
// 8-bit Fibonacci LFSR, free running every clock.
// Ports: clk, clear_n (async active-low, loads seed), seed (reset value),
//        q (current LFSR state).
module lfsr8
    import gerador_trepidacao_pkg::*;
(
    input  logic              clk,
    input  logic              clear_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic fb_c;

    // XOR of the tapped bits shifts in at the bottom
    assign fb_c = ^(q & LFSR_TAPS);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q <= seed;
        end else begin
            q <= {q[LFSR_W-2:0], fb_c};
        end
    end

endmodule

// File: rtl/gerador_trepidacao.sv
// Mechanical switch bounce emulator. A change on the clean level_in produces
// a burst of BOUNCES transition events on bounce_out separated by random (or
// fixed) gaps, followed by a settle interval and a one-cycle settled pulse.
// Ports: clk, clear_n (async active-low reset), level_in (clean level),
//        bounce_out (bouncing level), busy (burst/settle in progress),
//        settled (one-cycle pulse once bounce_out is stable at target).
module gerador_trepidacao
    import gerador_trepidacao_pkg::*;
#(
    parameter int unsigned       BOUNCES   = 5,
    parameter int unsigned       MAX_GAP   = 8,
    parameter int unsigned       FIXED_GAP = 0,
    parameter int unsigned       SETTLE    = 4,
    parameter logic [LFSR_W-1:0] SEED      = 8'hA5
) (
    input  logic clk,
    input  logic clear_n,
    input  logic level_in,
    output logic bounce_out,
    output logic busy,
    output logic settled
);

    // Elaboration-time parameter range checks
    if (BOUNCES < 1 || BOUNCES > 15 || (BOUNCES % 2) != 1) begin : g_bad_bounces
        $error("BOUNCES must be odd and within 1..15");
    end
    if (MAX_GAP < 2 || MAX_GAP > 128 || (MAX_GAP & (MAX_GAP - 1)) != 0) begin : g_bad_max_gap
        $error("MAX_GAP must be a power of two within 2..128");
    end
    if (FIXED_GAP > 128) begin : g_bad_fixed_gap
        $error("FIXED_GAP must be 0 or within 1..128");
    end
    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("SETTLE must be within 1..255");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("SEED must be nonzero");
    end

    localparam logic [GAP_W-1:0]    GAP_MASK    = GAP_W'(MAX_GAP - 1);
    localparam logic [GAP_W-1:0]    FIXED_GAP_V = GAP_W'(FIXED_GAP);
    localparam logic [SETTLE_W-1:0] SETTLE_V    = SETTLE_W'(SETTLE);
    localparam logic [EVT_W-1:0]    EVT_LAST    = EVT_W'(BOUNCES - 1);

    state_t              state_q, state_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [EVT_W-1:0]    evt_q, evt_d;
    logic                target_q, target_d;
    logic                bounce_d, busy_d, settled_d;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [GAP_W-1:0]    new_gap_c;
    logic                start_c;

    lfsr8 u_lfsr (
        .clk     (clk),
        .clear_n (clear_n),
        .seed    (SEED),
        .q       (lfsr_q)
    );

    // Gap to load for the next event
    assign new_gap_c = (FIXED_GAP != 0) ? FIXED_GAP_V : gap_from_lfsr(lfsr_q, GAP_MASK);

    // A level mismatch outside BOUNCE (re)starts a burst
    assign start_c = (level_in != bounce_out);

    // State and output registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= ST_IDLE;
            gap_q      <= '0;
            settle_q   <= '0;
            evt_q      <= '0;
            target_q   <= 1'b0;
            bounce_out <= 1'b0;
            busy       <= 1'b0;
            settled    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            settle_q   <= settle_d;
            evt_q      <= evt_d;
            target_q   <= target_d;
            bounce_out <= bounce_d;
            busy       <= busy_d;
            settled    <= settled_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        settle_d  = settle_q;
        evt_d     = evt_q;
        target_d  = target_q;
        bounce_d  = bounce_out;
        busy_d    = busy;
        settled_d = 1'b0;

        if ((state_q == ST_IDLE || state_q == ST_SETTLE) && start_c) begin
            // Event 1: start (or restart) a burst; restart wins over settled
            target_d = level_in;
            bounce_d = level_in;
            evt_d    = EVT_W'(1);
            busy_d   = 1'b1;
            if (BOUNCES == 1) begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_V;
                gap_d    = '0;
            end else begin
                state_d  = ST_BOUNCE;
                gap_d    = new_gap_c;
                settle_d = '0;
            end
        end else begin
            case (state_q)
                ST_BOUNCE: begin
                    // Track the clean level so the final event lands on the latest value
                    target_d = level_in;
                    if (gap_q <= GAP_W'(1)) begin
                        evt_d = evt_q + EVT_W'(1);
                        if (evt_q >= EVT_LAST) begin
                            bounce_d = target_d;
                            state_d  = ST_SETTLE;
                            settle_d = SETTLE_V;
                            gap_d    = '0;
                        end else begin
                            bounce_d = ~bounce_out;
                            gap_d    = new_gap_c;
                        end
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_q <= SETTLE_W'(1)) begin
                        settled_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                        settle_d  = '0;
                        evt_d     = '0;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_IDLE: begin
                    busy_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gerador_trepidacao.sv
// Self-checking bench: table-driven directed vectors with a scoreboard queue
// on a fixed-gap instance, a single-event instance, and a random-gap instance.
module tb_gerador_trepidacao;

    // {clear_n, level_in, exp bounce_out, exp busy, exp settled}
    typedef struct packed {
        logic clr;
        logic lvl;
        logic eb;
        logic ebusy;
        logic es;
    } vec_t;

    typedef struct packed {
        logic [7:0] row;
        logic [2:0] outs;
    } exp_t;

    localparam int NV = 65;

    logic clk;
    logic clear_fix, lvl_fix, bo_fix, busy_fix, set_fix;
    logic clear_one, lvl_one, bo_one, busy_one, set_one;
    logic clear_rnd, lvl_rnd, bo_rnd, busy_rnd, set_rnd;

    int   n_vec;
    int   n_err;
    int   gmin;
    int   gmax;
    vec_t vecs [NV];
    exp_t exp_q [$];

    gerador_trepidacao #(.BOUNCES(3), .MAX_GAP(8), .FIXED_GAP(2), .SETTLE(4), .SEED(8'hA5)) dut_fix (
        .clk(clk), .clear_n(clear_fix), .level_in(lvl_fix),
        .bounce_out(bo_fix), .busy(busy_fix), .settled(set_fix));

    gerador_trepidacao #(.BOUNCES(1), .MAX_GAP(8), .FIXED_GAP(1), .SETTLE(1), .SEED(8'hA5)) dut_one (
        .clk(clk), .clear_n(clear_one), .level_in(lvl_one),
        .bounce_out(bo_one), .busy(busy_one), .settled(set_one));

    gerador_trepidacao #(.BOUNCES(5), .MAX_GAP(8), .FIXED_GAP(0), .SETTLE(4), .SEED(8'hA5)) dut_rnd (
        .clk(clk), .clear_n(clear_rnd), .level_in(lvl_rnd),
        .bounce_out(bo_rnd), .busy(busy_rnd), .settled(set_rnd));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one table row, queue its expectation, compare after the edge
    task automatic apply_row(input int r);
        exp_t e;
        @(negedge clk);
        clear_fix = vecs[r].clr;
        lvl_fix   = vecs[r].lvl;
        exp_q.push_back('{row: 8'(r), outs: {vecs[r].eb, vecs[r].ebusy, vecs[r].es}});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("row %0d {bounce,busy,settled}", e.row),
              int'({bo_fix, busy_fix, set_fix}), int'(e.outs));
    endtask

    // One undisturbed random burst on dut_rnd, measured from its outputs
    task automatic random_burst(input int b);
        int   edge_n, last_ev, nev, bmin, bmax, nset, sdist, g;
        logic prev, done;
        @(negedge clk);
        lvl_rnd = ~lvl_rnd;
        prev    = bo_rnd;
        edge_n  = 0;
        last_ev = 0;
        nev     = 0;
        bmin    = 1000;
        bmax    = 0;
        nset    = 0;
        sdist   = -1;
        done    = 1'b0;
        while (!done && edge_n < 200) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (bo_rnd != prev) begin
                if (nev > 0) begin
                    g = edge_n - last_ev;
                    if (g < bmin) bmin = g;
                    if (g > bmax) bmax = g;
                end
                nev++;
                last_ev = edge_n;
                prev    = bo_rnd;
            end
            if (set_rnd) begin
                nset++;
                sdist = edge_n - last_ev;
                done  = 1'b1;
            end
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            if (set_rnd) nset++;
        end
        if (bmin < gmin) gmin = bmin;
        if (bmax > gmax) gmax = bmax;
        n_vec++;
        if (bmin < 1 || bmax > 8) begin
            n_err++;
            $display("FAIL rnd%0d gap range: min %0d max %0d, required within 1..8", b, bmin, bmax);
        end
        check($sformatf("rnd%0d transitions", b), nev, 5);
        check($sformatf("rnd%0d final level", b), int'(bo_rnd), int'(lvl_rnd));
        check($sformatf("rnd%0d settled pulses", b), nset, 1);
        check($sformatf("rnd%0d settle distance", b), sdist, 4);
        check($sformatf("rnd%0d busy after settle", b), int'(busy_rnd), 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        gmin  = 1000;
        gmax  = 0;
        clear_fix = 1'b0; lvl_fix = 1'b0;
        clear_one = 1'b0; lvl_one = 1'b0;
        clear_rnd = 1'b0; lvl_rnd = 1'b0;

        vecs = '{
            // reset, release with level low, 0->1 burst (edge k = row 4)
            5'b00_000, 5'b00_000, 5'b10_000, 5'b10_000,
            5'b11_110, 5'b11_110, 5'b11_010, 5'b11_010, 5'b11_110,
            5'b11_110, 5'b11_110, 5'b11_110, 5'b11_101, 5'b11_100, 5'b11_100,
            // 1->0 burst (k = row 15)
            5'b10_010, 5'b10_010, 5'b10_110, 5'b10_110, 5'b10_010,
            5'b10_010, 5'b10_010, 5'b10_010, 5'b10_001, 5'b10_000,
            // 0->1, level returns to 0 at k+3 (k = row 25)
            5'b11_110, 5'b11_110, 5'b11_010, 5'b10_010, 5'b10_010,
            5'b10_010, 5'b10_010, 5'b10_010, 5'b10_001, 5'b10_000,
            // 0->1, toggle back at k+6 during settle (k = row 35)
            5'b11_110, 5'b11_110, 5'b11_010, 5'b11_010, 5'b11_110, 5'b11_110,
            5'b10_010, 5'b10_010, 5'b10_110, 5'b10_110, 5'b10_010,
            5'b10_010, 5'b10_010, 5'b10_010, 5'b10_001, 5'b10_000,
            // burst interrupted by reset after row 53 (k = row 51)
            5'b11_110, 5'b11_110, 5'b11_010,
            // reset held over an edge, then release with level high
            5'b01_000,
            5'b11_110, 5'b11_110, 5'b11_010, 5'b11_010, 5'b11_110,
            5'b11_110, 5'b11_110, 5'b11_110, 5'b11_101, 5'b11_100
        };

        repeat (2) @(negedge clk);
        clear_one = 1'b1;
        clear_rnd = 1'b1;

        for (int r = 0; r <= 53; r++) apply_row(r);

        // Asynchronous reset mid-burst clears outputs without a clock edge
        @(negedge clk);
        clear_fix = 1'b0;
        #1;
        check("async clear {bounce,busy,settled}", int'({bo_fix, busy_fix, set_fix}), 0);

        for (int r = 54; r < NV; r++) apply_row(r);

        // Single-event burst goes straight to settle
        @(negedge clk);
        lvl_one = 1'b1;
        @(posedge clk); #1;
        check("one-event k", int'({bo_one, busy_one, set_one}), 6);
        @(posedge clk); #1;
        check("one-event k+1", int'({bo_one, busy_one, set_one}), 5);
        @(posedge clk); #1;
        check("one-event k+2", int'({bo_one, busy_one, set_one}), 4);

        for (int b = 0; b < 1000; b++) random_burst(b);
        check("random gap minimum seen", gmin, 1);
        check("random gap maximum seen", gmax, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
